// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: CPU fetch/data ports and single memory port of the arbiter.
interface unified_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_ins_o;
  logic              if_ack_o;
  logic [1:0]        d_ctrl_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;
  modport master (
    input  if_req_i, if_addr_i, d_ctrl_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    output if_ins_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o
  );
  modport slave (
    output if_req_i, if_addr_i, d_ctrl_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    input  if_ins_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises CPU fetch and data accesses onto one variable-latency memory.
module unified_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  unified_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t            r_state, w_next;
  logic              w_d_pend, w_grant_d, w_grant_if, w_done;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_req, r_mem_we, r_if_ack, r_d_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_ins, r_d_rdata;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;

  // Data wins unless fetch has already lost STARVE_MAX arbitrations in a row
  always_comb begin
    w_d_pend   = |bus.d_ctrl_i;
    w_grant_d  = (r_state == IDLE) && w_d_pend && (!bus.if_req_i || r_starve_cnt < SMAX);
    w_grant_if = (r_state == IDLE) && !w_grant_d && bus.if_req_i;
    w_done     = (r_state != IDLE) && bus.mem_ack_i;
    w_next     = w_grant_d ? D_ACC : w_grant_if ? IF_ACC : w_done ? IDLE : r_state;
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ins     <= '0;
      r_d_rdata    <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_if_ack <= w_done && r_state == IF_ACC;
      r_d_ack  <= w_done && r_state == D_ACC;
      r_if_ins  <= (w_done && r_state == IF_ACC) ? bus.mem_rdata_i : r_if_ins;
      r_d_rdata <= (w_done && r_state == D_ACC) ? bus.mem_rdata_i : r_d_rdata;
      if (w_grant_d || w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_grant_d && bus.d_ctrl_i[1];
        r_mem_addr  <= w_grant_d ? bus.d_addr_i : bus.if_addr_i;
        r_mem_wdata <= w_grant_d ? bus.d_wdata_i : '0;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
      end
      if (w_grant_if) r_starve_cnt <= '0;
      else if (w_grant_d && bus.if_req_i && r_starve_cnt < SMAX) r_starve_cnt <= r_starve_cnt + 4'd1;
    end

  always_comb begin
    bus.stall_o     = (bus.if_req_i & ~r_if_ack) | (w_d_pend & ~r_d_ack);
    bus.mem_req_o   = r_mem_req;
    bus.mem_we_o    = r_mem_we;
    bus.mem_addr_o  = r_mem_addr;
    bus.mem_wdata_o = r_mem_wdata;
    bus.if_ins_o    = r_if_ins;
    bus.if_ack_o    = r_if_ack;
    bus.d_rdata_o   = r_d_rdata;
    bus.d_ack_o     = r_d_ack;
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios with a latency-programmable memory model and
// scoreboard queues for memory requests, fetched instructions and load data.
module tb_unified_mem_arbiter;
  typedef struct {logic [31:0] a; logic we; logic [31:0] wd;} mreq_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int lat = 0, mcnt = 0, mem_en = 1, in_acc = 0;
  int n_if_ack = 0, n_d_ack = 0, if_t0 = 0, d_t0 = 0, if_lat = 0, d_lat = 0;
  int if_ack_cyc = 0, d_ack_cyc = 0, saved;
  logic prev_if_ack = 0, prev_d_ack = 0, stall_at_if_ack = 1, stall_at_d_ack = 1;
  mreq_t cur, e;
  mreq_t exp_mem[$];
  logic [31:0] exp_if[$], exp_d[$], d_next[$];
  logic [31:0] mem [logic [31:0]];

  unified_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  unified_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.if_ack_o) begin
      n_if_ack++; if_lat = cyc - if_t0; if_ack_cyc = cyc; stall_at_if_ack = bus.stall_o;
      chk("if_ack_width", prev_if_ack, 0);
      chk("if_ack_expected", 64'(exp_if.size() > 0), 1);
      if (exp_if.size() > 0) chk("if_ins", bus.if_ins_o, exp_if.pop_front());
      bus.if_req_i = 1'b0;
    end
    if (bus.d_ack_o) begin
      n_d_ack++; d_lat = cyc - d_t0; d_ack_cyc = cyc; stall_at_d_ack = bus.stall_o;
      chk("d_ack_width", prev_d_ack, 0);
      chk("d_ack_expected", 64'(exp_d.size() > 0), 1);
      if (exp_d.size() > 0) chk("d_rdata", bus.d_rdata_o, exp_d.pop_front());
      if (d_next.size() > 0) begin
        bus.d_addr_i = d_next.pop_front();
        bus.d_ctrl_i = 2'b01;
        exp_d.push_back(init_val(bus.d_addr_i));
        d_t0 = cyc;
      end else bus.d_ctrl_i = 2'b00;
    end
    prev_if_ack = bus.if_ack_o;
    prev_d_ack  = bus.d_ack_o;
    if (mem_en != 0) begin
      bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o && in_acc == 0) begin
        in_acc = 1; mcnt = 0;
        cur = '{bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o};
        chk("mem_req_expected", 64'(exp_mem.size() > 0), 1);
        if (exp_mem.size() > 0) begin
          e = exp_mem.pop_front();
          chk("mem_addr", bus.mem_addr_o, e.a);
          chk("mem_we", bus.mem_we_o, e.we);
          chk("mem_wdata", bus.mem_wdata_o, e.wd);
        end
      end else if (bus.mem_req_o) begin
        chk("mem_addr_stable", bus.mem_addr_o, cur.a);
        chk("mem_wdata_stable", {bus.mem_we_o, bus.mem_wdata_o}, {cur.we, cur.wd});
      end
      if (bus.mem_req_o) begin
        if (mcnt == lat) begin
          bus.mem_ack_i = 1'b1;
          bus.mem_rdata_i = rd(cur.a);
          if (cur.we) mem[cur.a] = cur.wd;
          in_acc = 0;
        end else mcnt++;
      end
    end
  endtask

  task automatic wait_acks(int ni, int nd);
    for (int i = 0; i < 80 && (n_if_ack < ni || n_d_ack < nd); i++) tick();
    chk("ack_timeout", 64'(n_if_ack >= ni && n_d_ack >= nd), 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_mem_req"}, bus.mem_req_o, 0);
    chk({tag, "_mem_we"}, bus.mem_we_o, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
    chk({tag, "_if_ins"}, bus.if_ins_o, 0);
    chk({tag, "_if_ack"}, bus.if_ack_o, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata_o, 0);
    chk({tag, "_d_ack"}, bus.d_ack_o, 0);
    chk({tag, "_stall"}, bus.stall_o, 0);
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.d_ctrl_i = 0; bus.d_addr_i = 0;
    bus.d_wdata_i = 0; bus.mem_rdata_i = 0; bus.mem_ack_i = 0;
    mem[32'h10] = 32'h8C01_0004;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // lone fetch, memory acks after 3 extra cycles
    lat = 3;
    exp_mem.push_back('{32'h10, 1'b0, 32'h0});
    exp_if.push_back(32'h8C01_0004);
    bus.if_addr_i = 32'h10; bus.if_req_i = 1'b1; if_t0 = cyc;
    #1 chk("fetch_stall_start", bus.stall_o, 1);
    for (int i = 0; i < 30 && n_if_ack < 1; i++) begin
      tick();
      if (bus.if_req_i) chk("fetch_stall_wait", bus.stall_o, 1);
    end
    chk("fetch_done", n_if_ack, 1);
    chk("fetch_latency", if_lat, 5);
    chk("fetch_stall_ack", stall_at_if_ack, 0);
    tick();
    chk("fetch_ack_cleared", bus.if_ack_o, 0);
    chk("fetch_ins_hold", bus.if_ins_o, 32'h8C01_0004);

    // store, memory acks in the first request cycle
    lat = 0;
    exp_mem.push_back('{32'h20, 1'b1, 32'hDEAD_BEEF});
    exp_d.push_back(init_val(32'h20));
    bus.d_addr_i = 32'h20; bus.d_wdata_i = 32'hDEAD_BEEF; bus.d_ctrl_i = 2'b10; d_t0 = cyc;
    wait_acks(1, 1);
    chk("store_latency", d_lat, 2);
    chk("store_stall_ack", stall_at_d_ack, 0);

    // simultaneous fetch and load: data first, then fetch
    lat = 1;
    exp_mem.push_back('{32'h80, 1'b0, 32'hDEAD_BEEF});
    exp_mem.push_back('{32'h40, 1'b0, 32'h0});
    exp_d.push_back(init_val(32'h80));
    exp_if.push_back(init_val(32'h40));
    bus.d_addr_i = 32'h80; bus.d_ctrl_i = 2'b01; bus.if_addr_i = 32'h40; bus.if_req_i = 1'b1;
    wait_acks(2, 2);
    chk("sim_d_before_if", 64'(d_ack_cyc < if_ack_cyc), 1);

    // starvation: fetch held against back-to-back loads
    lat = 0;
    bus.d_wdata_i = 0;
    foreach (d_next[i]) d_next.delete(i);
    d_next.push_back(32'h204); d_next.push_back(32'h208); d_next.push_back(32'h20C);
    exp_mem.push_back('{32'h200, 1'b0, 32'h0});
    exp_mem.push_back('{32'h204, 1'b0, 32'h0});
    exp_mem.push_back('{32'h208, 1'b0, 32'h0});
    exp_mem.push_back('{32'h100, 1'b0, 32'h0});
    exp_mem.push_back('{32'h20C, 1'b0, 32'h0});
    exp_d.push_back(init_val(32'h200));
    exp_if.push_back(init_val(32'h100));
    bus.d_addr_i = 32'h200; bus.d_ctrl_i = 2'b01; bus.if_addr_i = 32'h100; bus.if_req_i = 1'b1;
    wait_acks(3, 3);
    chk("starve_cleared", dut.r_starve_cnt, 0);
    chk("starve_if_before_load4", 64'(if_ack_cyc > d_ack_cyc), 1);
    wait_acks(3, 6);
    chk("starve_queue_drained", exp_mem.size(), 0);

    // ctrl 2'b11 acts as write; requester drops mid-access
    lat = 4;
    exp_mem.push_back('{32'h30, 1'b1, 32'h1234_5678});
    exp_d.push_back(init_val(32'h30));
    bus.d_addr_i = 32'h30; bus.d_wdata_i = 32'h1234_5678; bus.d_ctrl_i = 2'b11;
    tick(); tick();
    bus.d_ctrl_i = 2'b00;
    wait_acks(3, 7);
    saved = n_d_ack;
    tick(); tick();
    chk("drop_single_ack", n_d_ack, saved);
    chk("drop_idle", bus.mem_req_o, 0);
    chk("drop_rdata_hold", bus.d_rdata_o, init_val(32'h30));

    // asynchronous reset in the middle of a data access
    mem_en = 0;
    bus.d_addr_i = 32'h44; bus.d_ctrl_i = 2'b01;
    tick(); tick();
    chk("rst_access_live", bus.mem_req_o, 1);
    #2;
    bus.d_ctrl_i = 2'b00;
    rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("rst_stale_ack_idle", bus.mem_req_o, 0);
    tick();
    chk("rst_no_d_ack", bus.d_ack_o, 0);
    chk("rst_rdata_zero", bus.d_rdata_o, 0);
    chk("rst_no_if_ack", bus.if_ack_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
